dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the slave end of the MEM-stage load/store interface.
- Accepts one word load or store per transaction from the pipeline's EX/MEM outputs.
- Models a configurable number of wait states and back-pressures the whole pipeline with a stall signal until the access completes.
- Flags misaligned or out-of-range accesses. Replaces the zero-latency data memory as the memory model for slow-memory and MMIO bring-up.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the backing array; must be a power of two.
- WAIT_STATES, 2: stall cycles per access, range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request from the MEM stage.
- mem_write  in  1  store request from the MEM stage.
- address  in  32  byte address; must be word aligned.
- write_data  in  32  store data.
- read_data  out  32  load data; valid only in the completion cycle.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM while high.
- err  out  1  one-cycle pulse on a misaligned or out-of-range access.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values while rst=1 and on the following cycle: state=IDLE, stall=0, read_data=0, err=0, wait counter=0.
- Reset does not clear array contents.
- A request is mem_read|mem_write. If both are high, the access is treated as a write.
- WAIT_STATES=0 (no FSM):
  - read_data = array[index] combinationally; stall is never asserted.
  - Writes commit at the rising edge of the request cycle.
  - A read and a write to the same word in the same cycle return the old data.
- WAIT_STATES>0, FSM states IDLE, WAIT, DONE:
  - IDLE with a request: latch address, write_data and write flag; stall=1 combinationally in that cycle; load counter=WAIT_STATES-1; go to WAIT. If WAIT_STATES=1, go straight to DONE.
  - WAIT: stall=1; counter decrements; go to DONE when it reaches 0.
  - DONE: stall=0; read_data=array[latched index] for loads, else 0; stores commit at the end of this cycle; err is asserted here if applicable; always go to IDLE.
  - Each access therefore produces exactly WAIT_STATES stall cycles, and completes in cycle WAIT_STATES after acceptance.
  - Inputs are held stable by the pipeline while stall=1. Any input change after acceptance is ignored; latched values win.
  - The request seen in the IDLE cycle immediately after DONE is a new transaction. Back-to-back accesses therefore cost WAIT_STATES+1 cycles each.
- Address checks:
  - index = (address-BASE_ADDR)>>2, log2(DEPTH_WORDS) bits.
  - Out of range means address<BASE_ADDR or index>=DEPTH_WORDS.
  - Misaligned means address[1:0]!=0.
  - Either error: err=1 in the completion cycle, the store is suppressed, read_data=0. The access is not retried.
- Reset in the middle of an access: the FSM returns to IDLE, the pending store is dropped, and no err pulse is produced.
- No request in IDLE: outputs hold their reset values (read_data=0).

Optional Feature:
- Macro DMEM_RESPONDER_MMIO_EN.
- When defined, two memory-mapped words are decoded ahead of the range check, with the same timing as the array:
  - 32'hFFFF_FFF0: RW debug register, reset to 0, exported on an extra output port mmio_debug[31:0].
  - 32'hFFFF_FFF4: RO free-running 32-bit cycle counter, reset to 0, wraps at 2^32. Stores to it are ignored without err.
- When undefined: no mmio_debug port; both addresses are ordinary out-of-range accesses (err=1).

Decomposition:
- Package dmem_responder_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the MMIO address constants MMIO_DEBUG_ADDR and MMIO_CYCLE_ADDR;
  - the ADDR_W and DATA_W=32 constants.
- One sub-module, dmem_array: a single-port word RAM with synchronous write, combinational read, and parameter DEPTH_WORDS.
- The FSM, counter, decode and MMIO logic stay in dmem_responder.

Test Plan:
- WAIT_STATES=2; store 0xDEADBEEF at 0x10, then load 0x10.
  - Required: stall is high for 2 cycles on each access; read_data=0xDEADBEEF in the load's DONE cycle; err=0.
- WAIT_STATES=0; back-to-back stores then loads at 0x0, 0x4, 0x8.
  - Required: stall is never high; loads return the stored data in the same cycle.
- Load 0x12 (misaligned) and store to 0x400 with DEPTH_WORDS=256.
  - Required: err pulses for one cycle in DONE; read_data=0; a reload of 0x0 still shows the old value.
- Assert rst in the WAIT cycle of a store of 0x55 to 0x20.
  - Required: stall=0 the next cycle; a later load of 0x20 returns its pre-store value.
- Change address from 0x10 to 0x20 during WAIT of a load.
  - Required: the data returned is from 0x10.
- With DMEM_RESPONDER_MMIO_EN defined, store 0xA5 to 0xFFFF_FFF0, then read 0xFFFF_FFF4 twice, 10 cycles apart.
  - Required: mmio_debug=0xA5; the two counter reads differ by 10; err=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths, MMIO addresses and FSM state type for dmem_responder
package dmem_responder_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] MMIO_DEBUG_ADDR = 32'hFFFF_FFF0;
    localparam logic [ADDR_W-1:0] MMIO_CYCLE_ADDR = 32'hFFFF_FFF4;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage load/store bus between the pipeline (master) and data memory (slave)
interface dmem_if;
    import dmem_responder_pkg::*;
    logic mem_read;
    logic mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic stall;
    logic err;
    modport master(output mem_read, mem_write, address, write_data, input read_data, stall, err);
    modport slave(input mem_read, mem_write, address, write_data, output read_data, stall, err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous write and combinational read
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (we) mem[idx] <= wdata;
    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory slave with pipeline stall and access-error pulse.
// Optional MMIO debug/cycle registers are built when DMEM_RESPONDER_MMIO_EN is defined.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
`ifdef DMEM_RESPONDER_MMIO_EN
    output logic [DATA_W-1:0] mmio_debug,
`endif
    dmem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    logic req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, arr_rdata, rd;
    logic a_wr, a_valid, misal, oor, bad, arr_we;
    logic [ADDR_W-3:0] diff_w;
    assign req = bus.mem_read | bus.mem_write;
    // a_* is the access being completed this cycle: live inputs or the latched request
    generate
        if (WAIT_STATES == 0) begin : g_comb
            assign a_addr = bus.address;
            assign a_wdata = bus.write_data;
            assign a_wr = bus.mem_write;
            assign a_valid = req & ~rst;
            assign bus.stall = 1'b0;
        end else begin : g_fsm
            state_t state, state_n;
            logic [3:0] cnt, cnt_n;
            logic [ADDR_W-1:0] addr_l;
            logic [DATA_W-1:0] wdata_l;
            logic wr_l, stall_c;
            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= IDLE;
                    cnt <= '0;
                end else begin
                    state <= state_n;
                    cnt <= cnt_n;
                end
                if (state == IDLE && req) begin
                    addr_l <= bus.address;
                    wdata_l <= bus.write_data;
                    wr_l <= bus.mem_write;
                end
            end
            always_comb begin
                state_n = state;
                cnt_n = cnt;
                stall_c = 1'b0;
                case (state)
                    IDLE: if (req) begin
                        stall_c = 1'b1;
                        cnt_n = 4'(WAIT_STATES - 1);
                        state_n = (WAIT_STATES == 1) ? DONE : WAIT;
                    end
                    WAIT: begin
                        stall_c = 1'b1;
                        cnt_n = cnt - 4'd1;
                        state_n = (cnt == 4'd1) ? DONE : WAIT;
                    end
                    DONE: begin
                        cnt_n = '0;
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
            assign a_addr = addr_l;
            assign a_wdata = wdata_l;
            assign a_wr = wr_l;
            assign a_valid = (state == DONE) & ~rst;
            assign bus.stall = stall_c & ~rst;
        end
    endgenerate
    assign diff_w = a_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign misal = |a_addr[1:0];
    assign oor = (a_addr < BASE_ADDR) | (|(diff_w >> IDX_W));
    assign arr_we = a_valid & a_wr & ~misal & ~oor;
`ifdef DMEM_RESPONDER_MMIO_EN
    logic hit_dbg, hit_cyc;
    logic [DATA_W-1:0] dbg_q, cyc_q;
    assign hit_dbg = a_addr == MMIO_DEBUG_ADDR;
    assign hit_cyc = a_addr == MMIO_CYCLE_ADDR;
    assign bad = misal | (oor & ~hit_dbg & ~hit_cyc);
    assign rd = hit_dbg ? dbg_q : hit_cyc ? cyc_q : arr_rdata;
    assign mmio_debug = dbg_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_q <= '0;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (a_valid & a_wr & hit_dbg) dbg_q <= a_wdata;
        end
    end
`else
    assign bad = misal | oor;
    assign rd = arr_rdata;
`endif
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk(clk),
        .we(arr_we),
        .idx(diff_w[IDX_W-1:0]),
        .wdata(a_wdata),
        .rdata(arr_rdata)
    );
    assign bus.read_data = (a_valid & ~a_wr & ~bad) ? rd : '0;
    assign bus.err = a_valid & bad;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks a 2-wait-state and a zero-wait-state responder against a word-array model.
module tb_dmem_responder;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    dmem_if b2();
    dmem_if b0();
    logic [31:0] dbg2, dbg0;
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst(rst),
`ifdef DMEM_RESPONDER_MMIO_EN
        .mmio_debug(dbg2),
`endif
        .bus(b2.slave));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst),
`ifdef DMEM_RESPONDER_MMIO_EN
        .mmio_debug(dbg0),
`endif
        .bus(b0.slave));
`ifndef DMEM_RESPONDER_MMIO_EN
    assign dbg2 = '0;
    assign dbg0 = '0;
`endif
    int n_vec = 0, n_bad = 0;
    logic [31:0] mem [2][256];
    logic [31:0] dbg_m [2];
    typedef struct {logic r, w; logic [31:0] a, d, q; logic e;} vec_t;
    vec_t tbl[16];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask
    // Reference: 256-word array at base 0, optional debug register; the cycle counter is never modelled
    function automatic void ref_op(input int k, input logic r, input logic w, input logic [31:0] a,
                                   input logic [31:0] d, output logic [31:0] q, output logic e);
        logic is_dbg;
        is_dbg = 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
        is_dbg = a == 32'hFFFF_FFF0;
`endif
        e = (a % 4 != 0) || (a >= 32'h400 && !is_dbg);
        q = 0;
        if (!e && w) begin
            if (is_dbg) dbg_m[k] = d;
            else mem[k][a / 4] = d;
        end else if (!e && r) q = is_dbg ? dbg_m[k] : mem[k][a / 4];
    endfunction
    task automatic xact2(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output logic e, output int ns);
        bit done;
        done = 0; ns = 0; q = 'x; e = 'x;
        @(posedge clk); #1;
        b2.mem_read = r; b2.mem_write = w; b2.address = a; b2.write_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (b2.stall) ns++;
            else begin q = b2.read_data; e = b2.err; done = 1; end
        end
        if (!done) begin
            n_bad++;
            $display("FAIL xact2_timeout addr=%h got=no completion exp=completion", a);
        end
        @(posedge clk); #1;
        b2.mem_read = 0; b2.mem_write = 0;
    endtask
    task automatic xact0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output logic e, output int ns);
        @(posedge clk); #1;
        b0.mem_read = r; b0.mem_write = w; b0.address = a; b0.write_data = d;
        @(negedge clk);
        q = b0.read_data; e = b0.err; ns = int'(b0.stall);
    endtask
    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            7: return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            8: return 32'h400 + 32'($urandom_range(0, 1000) * 4);
            9: return 32'hFFFF_FFF0;
            default: return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
    endfunction
    logic [31:0] q, mq, c1, c2;
    logic e, me, r, w;
    logic [31:0] a, d;
    int ns, sel, bad_wait;
    bit fin;
    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1'b0, 1'b1, 32'h400, 32'h77,       32'h0,        1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'hC0DE0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h0,   32'h11111111, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h4,   32'h22222222, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h8,   32'h33333333, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h4,   32'h0,        32'h22222222, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h33333333, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'h14,  32'hAAAA5555, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h14,  32'h0,        32'hAAAA5555, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hC0DE00FF, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'h3FF, 32'h99,       32'h0,        1'b1};
`ifdef DMEM_RESPONDER_MMIO_EN
        tbl[15] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,  32'h0,        1'b0};
`else
        tbl[15] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,  32'h0,        1'b1};
`endif
        dbg_m[0] = 0; dbg_m[1] = 0;
        b2.mem_read = 1; b2.mem_write = 0; b2.address = 0; b2.write_data = 0;
        b0.mem_read = 1; b0.mem_write = 0; b0.address = 0; b0.write_data = 0;
        // Outputs stay at reset values while rst is high, even with a request pending
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_stall2", 32'(b2.stall), 0); chk("rst_err2", 32'(b2.err), 0); chk("rst_rd2", b2.read_data, 0);
            chk("rst_stall0", 32'(b0.stall), 0); chk("rst_err0", 32'(b0.err), 0); chk("rst_rd0", b0.read_data, 0);
        end
        @(posedge clk); #1;
        rst = 0; b2.mem_read = 0; b0.mem_read = 0;
        @(negedge clk);
        chk("idle_stall2", 32'(b2.stall), 0); chk("idle_rd2", b2.read_data, 0);
        chk("idle_rd0", b0.read_data, 0); chk("idle_err0", 32'(b0.err), 0);
        for (int i = 0; i < 256; i++) begin
            d = 32'hC0DE0000 | i;
            xact2(0, 1, 32'(i * 4), d, q, e, ns);
            xact0(0, 1, 32'(i * 4), d, q, e, ns);
            mem[0][i] = d; mem[1][i] = d;
        end
        for (int i = 0; i < 16; i++) begin
            xact2(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, q, e, ns);
            ref_op(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, mq, me);
            chk($sformatf("tbl%0d_rd_ws2", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_err_ws2", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_stalls_ws2", i), ns, 2);
            xact0(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, q, e, ns);
            ref_op(1, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, mq, me);
            chk($sformatf("tbl%0d_rd_ws0", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_err_ws0", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_stall_ws0", i), ns, 0);
        end
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            r = sel != 1; w = sel == 1 || sel == 2;
            a = rnd_addr(); d = $urandom;
            ref_op(i % 2, r, w, a, d, mq, me);
            if (i % 2 == 0) xact2(r, w, a, d, q, e, ns);
            else xact0(r, w, a, d, q, e, ns);
            chk($sformatf("rnd%0d_rd a=%h", i, a), q, mq);
            chk($sformatf("rnd%0d_err a=%h", i, a), 32'(e), 32'(me));
            chk($sformatf("rnd%0d_stalls", i), ns, (i % 2 == 0) ? 2 : 0);
        end
        @(posedge clk); #1;
        b0.mem_read = 0; b0.mem_write = 0;
        // Reset during the WAIT cycle of a store drops the store without an err pulse
        @(posedge clk); #1;
        b2.mem_write = 1; b2.address = 32'h20; b2.write_data = 32'h55;
        @(negedge clk);
        chk("rstmid_accept_stall", 32'(b2.stall), 1);
        @(posedge clk); #1;
        rst = 1; b2.mem_write = 0;
        @(negedge clk);
        chk("rstmid_stall_in_rst", 32'(b2.stall), 0); chk("rstmid_err_in_rst", 32'(b2.err), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstmid_stall_after", 32'(b2.stall), 0); chk("rstmid_err_after", 32'(b2.err), 0);
        chk("rstmid_rd_after", b2.read_data, 0);
        xact2(1, 0, 32'h20, 0, q, e, ns);
        chk("rstmid_reload", q, mem[0][8]);
        chk("rstmid_reload_err", 32'(e), 0);
        // Address changes during WAIT must not affect the latched load
        @(posedge clk); #1;
        b2.mem_read = 1; b2.address = 32'h10;
        @(posedge clk); #1;
        b2.address = 32'h20;
        fin = 0; bad_wait = 1;
        for (int i = 0; i < 10 && !fin; i++) begin
            @(negedge clk);
            if (!b2.stall) begin fin = 1; bad_wait = 0; q = b2.read_data; end
        end
        if (bad_wait != 0) begin
            n_bad++;
            $display("FAIL addr_change_timeout got=no completion exp=completion");
        end
        chk("addr_change_rd", q, mem[0][4]);
        @(posedge clk); #1;
        b2.mem_read = 0;
`ifdef DMEM_RESPONDER_MMIO_EN
        xact2(0, 1, 32'hFFFF_FFF0, 32'hA5, q, e, ns);
        ref_op(0, 0, 1, 32'hFFFF_FFF0, 32'hA5, mq, me);
        chk("mmio_dbg_err", 32'(e), 0);
        chk("mmio_dbg_port", dbg2, 32'hA5);
        xact2(1, 0, 32'hFFFF_FFF4, 0, c1, e, ns);
        chk("mmio_cyc1_err", 32'(e), 0);
        repeat (6) @(posedge clk);
        xact2(1, 0, 32'hFFFF_FFF4, 0, c2, e, ns);
        chk("mmio_cyc2_err", 32'(e), 0);
        chk("mmio_cyc_delta", c2 - c1, 10);
        xact2(0, 1, 32'hFFFF_FFF4, 32'h1234, q, e, ns);
        chk("mmio_cyc_store_err", 32'(e), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
